div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle RV32M divider in the EX stage. Executes DIV/DIVU/REM/REMU on operands read from the register file.
- Returns the result to the register file write port as a single-cycle write pulse (rd_waddr/rd_wdata/rd_wr_en).
- The pipeline stalls on busy_o.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
sys_clk_i  input  1  core clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
start_i  input  1  launch a division; sampled only when busy_o=0
op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
dividend_i  input  XLEN  rs1 value
divisor_i  input  XLEN  rs2 value
rd_addr_i  input  5  destination register index
flush_i  input  1  abort the in-flight operation
busy_o  output  1  high while an operation is in flight; EX stall request
rd_waddr_o  output  5  register file write address
rd_wdata_o  output  XLEN  register file write data
rd_wr_en_o  output  1  register file write strobe, one-cycle pulse

Behaviour:
- Reset: rst_n_i low asynchronously forces state IDLE, counter 0, busy_o=0, rd_waddr_o=0, rd_wdata_o=0, rd_wr_en_o=0, and clears all internal registers.
- Reset mid-operation discards the operation; no write follows the reset release.

States:
- IDLE: busy_o=0.
  - On start_i=1 at edge E0: latch op_i, rd_addr_i, dividend, divisor, and the result sign.
  - Signed ops latch absolute values: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Go to CALC.
- CALC: busy_o=1; counter runs 0..31.
  - Each edge: shift the partial remainder left by 1, bringing in the next dividend MSB.
  - Trial-subtract the divisor, using a 33-bit subtraction to keep the borrow.
  - If no borrow, keep the difference and set quotient bit to 1; otherwise restore and set 0.
  - Counter=31 at an edge: go to DONE.
- DONE: busy_o=1 for exactly one cycle; outputs register on the entering edge E33.
  - rd_waddr_o = latched rd.
  - rd_wdata_o = sign-corrected quotient (DIV/DIVU) or remainder (REM/REMU).
  - rd_wr_en_o = 1, unless latched rd = 0, in which case rd_wr_en_o stays 0 with unchanged timing.
  - Next edge E34: rd_wr_en_o=0, back to IDLE; a new start_i can be sampled at E34.
- Latency: start sampled at E0; write pulse high between E33 and E34.

Outputs and control rules:
- rd_wdata_o and rd_waddr_o hold their last values after the pulse.
- start_i while busy_o=1 is ignored; no queuing.
- flush_i=1 in CALC or DONE: next edge goes to IDLE with busy_o=0 and rd_wr_en_o=0, and the pending write is dropped.
  - flush_i has priority over a DONE-cycle write: if flush_i=1 during the DONE cycle, no write occurs.
  - flush_i in IDLE has no effect.
  - flush_i=1 together with start_i in IDLE: flush wins and start is dropped.

Special cases (RISC-V defined, no trap):
- Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend unchanged.
- DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM returns 0.
- These results are muxed in DONE, overriding the datapath.

Arithmetic:
- Negation is two's complement at XLEN bits.
- abs(0x80000000) is handled as unsigned 0x80000000.

Optional Feature:
Macro DIV_FAST_SPECIAL_EN.
- Defined: special cases are detected in IDLE at start (divisor 0, or signed overflow on DIV/REM). The FSM goes IDLE->DONE directly, skipping CALC. The write pulse is high between E1 and E2, busy_o is high for one cycle, and the next start can be sampled at E2.
- Undefined: special cases run the full 32 CALC iterations; latency is identical to normal operations (pulse E33–E34). Results are the same either way.

Test Plan:
1. DIVU 100/7, rd=5, start at E0 -> single rd_wr_en_o pulse E33–E34, rd_waddr_o=5, rd_wdata_o=14; repeat with REMU -> 2; busy_o falls at E34.
2. DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF.
3. DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of same -> 0. Latency is 33 edges without DIV_FAST_SPECIAL_EN and 1 edge with it.
4. Second start_i pulses at E5 and E20 -> ignored, exactly one write. flush_i at E10 -> busy_o=0 at E11, no write. New start at E12 -> write at E45–E46.
5. rst_n_i low mid-CALC (E20) -> all outputs 0 immediately, without waiting for a clock edge. Release and run 40 cycles idle -> no rd_wr_en_o pulse.
6. rd_addr_i=0, DIVU 9/3 -> busy_o high for E0–E34 as normal, rd_wr_en_o never asserted.

Source files
------------

// File: rtl/div_unit_if.sv
// Register-file side bundle for the multi-cycle RV32M divider (div_unit).
interface div_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic [4:0]      rd_waddr_o;
  logic [XLEN-1:0] rd_wdata_o;
  logic            rd_wr_en_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    input  busy_o, rd_waddr_o, rd_wdata_o, rd_wr_en_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    output busy_o, rd_waddr_o, rd_wdata_o, rd_wr_en_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
// Define DIV_FAST_SPECIAL_EN to retire divide-by-zero and signed overflow straight from IDLE.
module div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic       sys_clk_i,
  input logic       rst_n_i,
  div_unit_if.slave bus
);

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  // FIX sits between the last iteration and DONE so the write pulse lands E33-E34.
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvs_q, a_q;
  logic [4:0]       rd_q;
  logic             is_rem_q, q_neg_q, r_neg_q, divz_q, ovf_q, fast_q;
  logic [4:0]       waddr_q;
  logic [XLEN-1:0]  wdata_q;
  logic             wr_en_q;
  logic             busy;

  logic            a_neg_in, b_neg_in, divz_in, ovf_in, fast_special, launch;
  logic [XLEN-1:0] a_abs_in, b_abs_in;
  logic [XLEN:0]   sh, diff;
  logic            borrow;
  logic [XLEN-1:0] q_fix, r_fix, result;

  function automatic logic [XLEN-1:0] special_res(input logic is_rem, input logic divz,
                                                  input logic [XLEN-1:0] a);
    if (divz) return is_rem ? a : '1;
    return is_rem ? '0 : INT_MIN;
  endfunction

  assign launch   = bus.start_i & ~bus.flush_i;
  assign a_neg_in = ~bus.op_i[0] & bus.dividend_i[XLEN-1];
  assign b_neg_in = ~bus.op_i[0] & bus.divisor_i[XLEN-1];
  assign a_abs_in = a_neg_in ? -bus.dividend_i : bus.dividend_i;
  assign b_abs_in = b_neg_in ? -bus.divisor_i : bus.divisor_i;
  assign divz_in  = (bus.divisor_i == '0);
  assign ovf_in   = ~bus.op_i[0] & (bus.dividend_i == INT_MIN) & (bus.divisor_i == '1);

`ifdef DIV_FAST_SPECIAL_EN
  assign fast_special = divz_in | ovf_in;
`else
  assign fast_special = 1'b0;
`endif

  // Trial subtraction kept at XLEN+1 bits so the top bit is the borrow.
  assign sh     = {rem_q, quo_q[XLEN-1]};
  assign diff   = sh - {1'b0, dvs_q};
  assign borrow = diff[XLEN];

  assign q_fix  = q_neg_q ? -quo_q : quo_q;
  assign r_fix  = r_neg_q ? -rem_q : rem_q;
  assign result = (divz_q | ovf_q) ? special_res(is_rem_q, divz_q, a_q)
                                   : (is_rem_q ? r_fix : q_fix);

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (launch) state_d = fast_special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (bus.flush_i)            state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX:   state_d = bus.flush_i ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      rd_q     <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      divz_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fast_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wr_en_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (launch) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= a_abs_in;
            dvs_q    <= b_abs_in;
            a_q      <= bus.dividend_i;
            rd_q     <= bus.rd_addr_i;
            is_rem_q <= bus.op_i[1];
            q_neg_q  <= a_neg_in ^ b_neg_in;
            r_neg_q  <= a_neg_in;
            divz_q   <= divz_in;
            ovf_q    <= ovf_in;
            fast_q   <= fast_special;
          end
        end
        S_CALC: begin
          if (!bus.flush_i) begin
            rem_q <= borrow ? sh[XLEN-1:0] : diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ~borrow};
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!bus.flush_i) begin
            waddr_q <= rd_q;
            wdata_q <= result;
            wr_en_q <= (rd_q != '0);
          end
        end
        S_DONE: begin
          // Fast special-case path registers its result on the way out of DONE.
          fast_q <= 1'b0;
          if (fast_q && !bus.flush_i) begin
            waddr_q <= rd_q;
            wdata_q <= result;
            wr_en_q <= (rd_q != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o     = busy;
  assign bus.rd_waddr_o = waddr_q;
  assign bus.rd_wdata_o = wdata_q;
  assign bus.rd_wr_en_o = wr_en_q & ~(bus.flush_i & busy);

endmodule

// File: tb/tb_div_unit.sv
// Directed scoreboard bench for div_unit; write latencies follow DIV_FAST_SPECIAL_EN.
module tb_div_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .sys_clk_i (clk),
    .rst_n_i   (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPL = 1;
  localparam int SPB = 1;
`else
  localparam int SPL = 33;
  localparam int SPB = 34;
`endif

  typedef struct {
    int          c;
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  checks   = 0;
  int  failures = 0;

  always @(negedge clk)
    if (bus.rd_wr_en_o === 1'b1) obs_q.push_back('{cyc, bus.rd_waddr_o, bus.rd_wdata_o});

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic wait_neg(input int n);
    int g = 0;
    do begin @(negedge clk); g++; end while (cyc < n && g < 300);
    chk("wait_neg", cyc, n);
  endtask

  task automatic at_pos(input int n);
    int g = 0;
    do begin @(posedge clk); #2; g++; end while (cyc < n && g < 300);
    chk("at_pos", cyc, n);
  endtask

  task automatic check_writes(input string tag);
    wr_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ":present"}, 32'(obs_q.size() > 0), 32'd1);
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        chk({tag, ":cycle"}, o.c, e.c);
        chk({tag, ":waddr"}, 32'(o.rd), 32'(e.rd));
        chk({tag, ":wdata"}, o.d, e.d);
      end
    end
    chk({tag, ":extra"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int e0);
    @(posedge clk); #2;
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.rd_addr_i  = rd;
    e0 = cyc + 1;
    @(posedge clk); #2;
    bus.start_i = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                       input int lat, input int blen);
    int e0;
    launch(op, a, b, rd, e0);
    if (rd != 5'd0) exp_q.push_back('{e0 + lat, rd, res});
    wait_neg(e0 + blen - 1);
    chk({tag, ":busy_hi"}, 32'(bus.busy_o), 32'd1);
    wait_neg(e0 + blen);
    chk({tag, ":busy_lo"}, 32'(bus.busy_o), 32'd0);
    wait_neg(e0 + lat + 2);
    #1;
    check_writes(tag);
  endtask

  initial begin
    int e0;
    bus.start_i    = 1'b0;
    bus.op_i       = 2'b00;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.rd_addr_i  = '0;
    bus.flush_i    = 1'b0;

    #1;
    chk("rst_busy",  32'(bus.busy_o),     32'd0);
    chk("rst_waddr", 32'(bus.rd_waddr_o), 32'd0);
    chk("rst_wdata", bus.rd_wdata_o,      32'd0);
    chk("rst_wr_en", 32'(bus.rd_wr_en_o), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    do_op("divu",      2'b01, 32'd100,       32'd7,          5'd5, 32'd14,         33, 34);
    do_op("remu",      2'b11, 32'd100,       32'd7,          5'd5, 32'd2,          33, 34);
    do_op("div_neg",   2'b00, 32'hFFFFFFF9,  32'd2,          5'd6, 32'hFFFFFFFD,   33, 34);
    do_op("rem_neg",   2'b10, 32'hFFFFFFF9,  32'd2,          5'd6, 32'hFFFFFFFF,   33, 34);
    do_op("divu_big",  2'b01, 32'hFFFFFFFF,  32'h10,         5'd7, 32'h0FFFFFFF,   33, 34);
    do_op("rem_mixed", 2'b10, 32'd7,         32'hFFFFFFFE,   5'd8, 32'd1,          33, 34);
    do_op("div_zero",  2'b00, 32'd5,         32'd0,          5'd3, 32'hFFFFFFFF,   SPL, SPB);
    do_op("rem_zero",  2'b10, 32'd5,         32'd0,          5'd3, 32'd5,          SPL, SPB);
    do_op("divu_zero", 2'b01, 32'hDEADBEEF,  32'd0,          5'd4, 32'hFFFFFFFF,   SPL, SPB);
    do_op("remu_zero", 2'b11, 32'hDEADBEEF,  32'd0,          5'd4, 32'hDEADBEEF,   SPL, SPB);
    do_op("div_ovf",   2'b00, 32'h80000000,  32'hFFFFFFFF,   5'd9, 32'h80000000,   SPL, SPB);
    do_op("rem_ovf",   2'b10, 32'h80000000,  32'hFFFFFFFF,   5'd9, 32'd0,          SPL, SPB);
    do_op("rd_zero",   2'b01, 32'd9,         32'd3,          5'd0, 32'd3,          33, 34);

    // Extra start pulses while busy are ignored.
    launch(2'b01, 32'd1000, 32'd10, 5'd7, e0);
    exp_q.push_back('{e0 + 33, 5'd7, 32'd100});
    at_pos(e0 + 4);
    bus.start_i = 1'b1; bus.op_i = 2'b11; bus.dividend_i = 32'd3; bus.divisor_i = 32'd2;
    bus.rd_addr_i = 5'd8;
    at_pos(e0 + 5);
    bus.start_i = 1'b0;
    at_pos(e0 + 19);
    bus.start_i = 1'b1;
    at_pos(e0 + 20);
    bus.start_i = 1'b0;
    wait_neg(e0 + 35);
    #1;
    check_writes("busy_start");

    // Flush mid-CALC, then a fresh start.
    launch(2'b01, 32'd50, 32'd5, 5'd9, e0);
    at_pos(e0 + 10);
    bus.flush_i = 1'b1;
    at_pos(e0 + 11);
    bus.flush_i = 1'b0;
    bus.start_i = 1'b1; bus.op_i = 2'b01; bus.dividend_i = 32'd81; bus.divisor_i = 32'd9;
    bus.rd_addr_i = 5'd10;
    exp_q.push_back('{e0 + 45, 5'd10, 32'd9});
    wait_neg(e0 + 11);
    chk("flush:busy_lo", 32'(bus.busy_o), 32'd0);
    at_pos(e0 + 12);
    bus.start_i = 1'b0;
    wait_neg(e0 + 47);
    #1;
    check_writes("flush_restart");

    // Flush during DONE drops the write.
    launch(2'b01, 32'd50, 32'd5, 5'd11, e0);
    at_pos(e0 + 33);
    bus.flush_i = 1'b1;
    #1;
    chk("flush_done:wr_en", 32'(bus.rd_wr_en_o), 32'd0);
    chk("flush_done:busy",  32'(bus.busy_o),     32'd1);
    at_pos(e0 + 34);
    bus.flush_i = 1'b0;
    chk("flush_done:busy_lo", 32'(bus.busy_o), 32'd0);
    wait_neg(e0 + 36);
    #1;
    check_writes("flush_done");

    // Flush with start in IDLE: start is dropped.
    @(posedge clk); #2;
    bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 2'b01;
    bus.dividend_i = 32'd4; bus.divisor_i = 32'd2; bus.rd_addr_i = 5'd12;
    @(posedge clk); #2;
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    chk("flush_idle:busy", 32'(bus.busy_o), 32'd0);
    repeat (40) @(negedge clk);
    #1;
    check_writes("flush_idle");

    // Asynchronous reset mid-CALC clears outputs immediately.
    launch(2'b01, 32'd77, 32'd7, 5'd13, e0);
    at_pos(e0 + 20);
    rst_n = 1'b0;
    #1;
    chk("arst:busy",  32'(bus.busy_o),     32'd0);
    chk("arst:waddr", 32'(bus.rd_waddr_o), 32'd0);
    chk("arst:wdata", bus.rd_wdata_o,      32'd0);
    chk("arst:wr_en", 32'(bus.rd_wr_en_o), 32'd0);
    at_pos(e0 + 22);
    rst_n = 1'b1;
    wait_neg(e0 + 62);
    #1;
    check_writes("arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
